uart_tx_fsm: RTL and testbench



---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_serializer.sv | 51 +++++
 rtl/uart_tx_fsm.sv | 120 ++++++++++++
 tb/tb_uart_tx_fsm.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, TX mux select
// codes and parity-type encoding.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_STOP  = 2'b01;
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_PAR   = 2'b11;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Line select seen by the TX mux while the FSM sits in a given state.
    function automatic logic [1:0] sel_decode(input uart_tx_state_e state);
        logic [1:0] sel;
        case (state)
            START:   sel = SEL_START;
            DATA:    sel = SEL_DATA;
            PARITY:  sel = SEL_PAR;
            STOP:    sel = SEL_STOP;
            IDLE:    sel = SEL_STOP;
            default: sel = SEL_STOP;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/uart_serializer.sv
// Load/shift register and bit counter; presents the payload LSB-first and
// flags the last data bit to the controlling FSM.
module uart_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  clear,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  ser_data,
    output logic                  done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_r;
    logic [CNT_W-1:0]      cnt_r;

    // Payload shift register: parallel load on accept, shift right per data bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= '0;
        end else if (load) begin
            shift_r <= load_data;
        end else if (shift) begin
            shift_r <= shift_r >> 1;
        end else begin
            shift_r <= shift_r;
        end
    end

    // Bit counter: zeroed before the data phase, advanced with every shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (load || clear) begin
            cnt_r <= '0;
        end else if (shift) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign ser_data = shift_r[0];
    assign done     = (cnt_r == LAST_BIT);

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit controller: accepts a byte on handshake, sequences
// start/data/parity/stop via mux_sel and supplies serial data and parity.
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic [1:0]            mux_sel,
    output logic                  busy
);

    uart_tx_state_e state_r;
    uart_tx_state_e state_s;
    logic           par_en_r;
    logic           par_bit_r;
    logic [1:0]     mux_sel_r;
    logic           busy_r;
    logic           accept_s;
    logic           clear_s;
    logic           shift_s;
    logic           done_s;

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                         input logic                  typ);
        logic p;
        if (typ == PAR_ODD) begin
            p = ~^data;
        end else begin
            p = ^data;
        end
        return p;
    endfunction

    uart_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept_s),
        .clear     (clear_s),
        .shift     (shift_s),
        .load_data (p_data),
        .ser_data  (ser_data),
        .done      (done_s)
    );

    // Next-state and serializer control decode.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        clear_s  = 1'b0;
        shift_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (data_valid) begin
                    accept_s = 1'b1;
                    state_s  = START;
                end else begin
                    state_s  = IDLE;
                end
            end
            START: begin
                clear_s = 1'b1;
                state_s = DATA;
            end
            DATA: begin
                shift_s = 1'b1;
                if (done_s) begin
                    state_s = par_en_r ? PARITY : STOP;
                end else begin
                    state_s = DATA;
                end
            end
            PARITY:  state_s = STOP;
            STOP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register; outputs are decoded from the next state so they line up
    // with the state register while coming straight out of flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            mux_sel_r <= SEL_STOP;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            mux_sel_r <= sel_decode(state_s);
            busy_r    <= (state_s != IDLE);
        end
    end

    // Frame options captured on accept so mid-frame input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_en_r  <= 1'b0;
            par_bit_r <= 1'b0;
        end else if (accept_s) begin
            par_en_r  <= par_en;
            par_bit_r <= calc_parity(p_data, par_typ);
        end else begin
            par_en_r  <= par_en_r;
            par_bit_r <= par_bit_r;
        end
    end

    assign par_bit = par_bit_r;
    assign mux_sel = mux_sel_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed self-checking bench for uart_tx_fsm (DATA_WIDTH = 8).
module tb_uart_tx_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] p_data = 8'h00;
    logic       data_valid = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       ser_data;
    logic       par_bit;
    logic [1:0] mux_sel;
    logic       busy;

    int errors = 0;
    int checks = 0;

    uart_tx_fsm #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .ser_data   (ser_data),
        .par_bit    (par_bit),
        .mux_sel    (mux_sel),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (mux_sel !== 2'b01) begin errors++; $display("FAIL reset_mux_sel got=%b exp=01", mux_sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ser_data !== 1'b0) begin errors++; $display("FAIL reset_ser_data got=%b exp=0", ser_data); end
        checks++; if (par_bit !== 1'b0) begin errors++; $display("FAIL reset_par_bit got=%b exp=0", par_bit); end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (mux_sel !== 2'b01 || busy !== 1'b0 || ser_data !== 1'b0 || par_bit !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset cyc=%0d got mux=%b busy=%b ser=%b par=%b exp mux=01 busy=0 ser=0 par=0",
                         i, mux_sel, busy, ser_data, par_bit);
            end
        end
    endtask

    // One full frame; optionally pulses data_valid with 0xFF during data bit 3.
    task automatic test_frame(input string tag, input logic [7:0] d, input logic pe,
                              input logic pt, input logic exp_par, input bit pulse_mid);
        int busy_cnt;
        busy_cnt = 0;
        @(negedge clk);
        p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        p_data = ~d; par_en = ~pe; par_typ = ~pt;
        if (busy === 1'b1) busy_cnt++;
        checks++; if (mux_sel !== 2'b00 || busy !== 1'b1) begin errors++;
            $display("FAIL %s start got mux=%b busy=%b exp mux=00 busy=1", tag, mux_sel, busy); end
        checks++; if (par_bit !== exp_par) begin errors++;
            $display("FAIL %s par_bit got=%b exp=%b", tag, par_bit, exp_par); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (pulse_mid && i == 3) begin data_valid = 1'b1; p_data = 8'hFF; end
            if (pulse_mid && i == 4) data_valid = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            checks++;
            if (mux_sel !== 2'b10 || ser_data !== d[i] || busy !== 1'b1) begin errors++;
                $display("FAIL %s data bit=%0d got mux=%b ser=%b busy=%b exp mux=10 ser=%b busy=1",
                         tag, i, mux_sel, ser_data, busy, d[i]); end
        end
        data_valid = 1'b0;
        if (pe) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            checks++;
            if (mux_sel !== 2'b11 || par_bit !== exp_par) begin errors++;
                $display("FAIL %s parity got mux=%b par=%b exp mux=11 par=%b", tag, mux_sel, par_bit, exp_par); end
        end
        @(negedge clk);
        if (busy === 1'b1) busy_cnt++;
        checks++; if (mux_sel !== 2'b01 || busy !== 1'b1) begin errors++;
            $display("FAIL %s stop got mux=%b busy=%b exp mux=01 busy=1", tag, mux_sel, busy); end
        @(negedge clk);
        if (busy === 1'b1) busy_cnt++;
        checks++; if (mux_sel !== 2'b01 || busy !== 1'b0) begin errors++;
            $display("FAIL %s idle got mux=%b busy=%b exp mux=01 busy=0", tag, mux_sel, busy); end
        checks++; if (busy_cnt != (pe ? 11 : 10)) begin errors++;
            $display("FAIL %s busy_len got=%0d exp=%0d", tag, busy_cnt, pe ? 11 : 10); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic [1:0] exp_sel;
        logic       exp_busy;
        int         guard;
        d = 8'h3C;
        @(negedge clk);
        p_data = d; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            exp_busy = 1'b1;
            if (c == 0 || c == 11) exp_sel = 2'b00;
            else if (c == 9) exp_sel = 2'b01;
            else if (c == 10) begin exp_sel = 2'b01; exp_busy = 1'b0; end
            else exp_sel = 2'b10;
            checks++;
            if (mux_sel !== exp_sel || busy !== exp_busy) begin errors++;
                $display("FAIL b2b cyc=%0d got mux=%b busy=%b exp mux=%b busy=%b", c, mux_sel, busy, exp_sel, exp_busy); end
            if (exp_sel == 2'b10) begin
                checks++;
                if (ser_data !== d[(c < 10) ? c - 1 : c - 12]) begin errors++;
                    $display("FAIL b2b_ser cyc=%0d got=%b exp=%b", c, ser_data, d[(c < 10) ? c - 1 : c - 12]); end
            end
        end
        data_valid = 1'b0;
        guard = 0;
        while (busy !== 1'b0 && guard < 20) begin @(negedge clk); guard++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain got busy=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        p_data = 8'hA5; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (mux_sel !== 2'b10) begin errors++; $display("FAIL mid_pre_reset got mux=%b exp=10", mux_sel); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mux_sel !== 2'b01 || busy !== 1'b0 || ser_data !== 1'b0 || par_bit !== 1'b0) begin errors++;
            $display("FAIL mid_async_reset got mux=%b busy=%b ser=%b par=%b exp mux=01 busy=0 ser=0 par=0",
                     mux_sel, busy, ser_data, par_bit); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (mux_sel !== 2'b01 || busy !== 1'b0) begin errors++;
            $display("FAIL mid_post_release got mux=%b busy=%b exp mux=01 busy=0", mux_sel, busy); end
        test_frame("fresh_5a_odd", 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        test_frame("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        test_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
        test_frame("07_even_ignore", 8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
